// File: rtl/gene_net_pkg.sv
// Shared constants for the gene-network stepper: state width, FSM state
// encodings and halt-cause encodings.
package gene_net_pkg;

  localparam int unsigned STATE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_FIXED   = 2'd1,
    CAUSE_PERIOD2 = 2'd2,
    CAUSE_LIMIT   = 2'd3
  } cause_t;

endpackage

// File: rtl/gene_net_rule.sv
// Combinational next-state rule: each gene takes its lower neighbour (wrapping)
// and is flipped by its own value where the regulation mask is set.
module gene_net_rule
  import gene_net_pkg::*;
(
  input  logic [STATE_W-1:0] x,
  input  logic [STATE_W-1:0] mask,
  output logic [STATE_W-1:0] nx
);

  assign nx = {x[STATE_W-2:0], x[STATE_W-1]} ^ (x & mask);

endmodule

// File: rtl/gene_net_stepper.sv
// Steps the gene network once per accepted output and halts on a fixed point,
// a period-2 cycle (only when GENE_NET_PERIOD2_EN is defined) or the step limit.
module gene_net_stepper
  import gene_net_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] init_val,
  input  logic [STATE_W-1:0] reg_mask,
  output logic [STATE_W-1:0] x,
  output logic               x_valid,
  input  logic               x_ready,
  output logic               done,
  output logic [1:0]         cause,
  output logic [7:0]         step_cnt
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

  state_t             r_state;
  cause_t             r_cause;
  logic [STATE_W-1:0] r_x;
  logic [STATE_W-1:0] r_mask;
  logic [7:0]         r_stepCnt;
  logic               r_xValid;
  logic               r_done;

  logic [STATE_W-1:0] w_nx;
  logic               w_accept;
  logic               w_fixed;
  logic               w_period2;
  logic               w_limit;
  logic               w_load;
  logic               w_advance;

  gene_net_rule u_rule (
    .x    (r_x),
    .mask (r_mask),
    .nx   (w_nx)
  );

  assign w_accept  = r_xValid & x_ready;
  assign w_fixed   = (w_nx == r_x);
  assign w_limit   = (r_stepCnt == MAX_CNT);
  assign w_load    = start & (r_state != ST_RUN);
  assign w_advance = w_accept & ~w_fixed & ~w_period2 & ~w_limit;

`ifdef GENE_NET_PERIOD2_EN
  logic [STATE_W-1:0] r_prev;

  // prev trails x by one advance so a two-state oscillation can be spotted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else if (w_load) begin
      r_prev <= '0;
    end else if (w_advance) begin
      r_prev <= r_x;
    end
  end

  assign w_period2 = (r_stepCnt != 8'd0) && (w_nx == r_prev);
`else
  assign w_period2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cause   <= CAUSE_NONE;
      r_x       <= '0;
      r_mask    <= '0;
      r_stepCnt <= '0;
      r_xValid  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_cause   <= CAUSE_NONE;
            r_x       <= init_val;
            r_mask    <= reg_mask;
            r_stepCnt <= '0;
            r_xValid  <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          // halt checks are prioritised; only a non-halting accept advances
          if (w_accept) begin
            if (w_fixed) begin
              r_state  <= ST_DONE;
              r_cause  <= CAUSE_FIXED;
              r_xValid <= 1'b0;
              r_done   <= 1'b1;
            end else if (w_period2) begin
              r_state  <= ST_DONE;
              r_cause  <= CAUSE_PERIOD2;
              r_xValid <= 1'b0;
              r_done   <= 1'b1;
            end else if (w_limit) begin
              r_state  <= ST_DONE;
              r_cause  <= CAUSE_LIMIT;
              r_xValid <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_x       <= w_nx;
              r_stepCnt <= r_stepCnt + 8'd1;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_xValid <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign x        = r_x;
  assign x_valid  = r_xValid;
  assign done     = r_done;
  assign cause    = r_cause;
  assign step_cnt = r_stepCnt;

endmodule

// File: tb/tb_gene_net_stepper.sv
// Directed self-checking bench for gene_net_stepper; expectations follow
// GENE_NET_PERIOD2_EN when it is defined for the build.
module tb_gene_net_stepper;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] init_val;
  logic [7:0] reg_mask;
  logic [7:0] x;
  logic       x_valid;
  logic       x_ready;
  logic       done;
  logic [1:0] cause;
  logic [7:0] step_cnt;

  int testsRun;
  int testsFailed;

  gene_net_stepper #(.MAX_STEPS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .init_val (init_val),
    .reg_mask (reg_mask),
    .x        (x),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .done     (done),
    .cause    (cause),
    .step_cnt (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle; called at a negedge, returns at the next one
  task automatic applyStimulus(input logic [7:0] initV, input logic [7:0] maskV);
    start    = 1'b1;
    init_val = initV;
    reg_mask = maskV;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneWithinBudget", {7'b0, done}, 8'h01);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_x"}, x, 8'h00);
    checkOutput({tag, "_xValid"}, {7'b0, x_valid}, 8'h00);
    checkOutput({tag, "_done"}, {7'b0, done}, 8'h00);
    checkOutput({tag, "_cause"}, {6'b0, cause}, 8'h00);
    checkOutput({tag, "_stepCnt"}, step_cnt, 8'h00);
  endtask

  logic [7:0] tglExp [6] = '{8'h03, 8'h03, 8'h05, 8'h05, 8'h0F, 8'h0F};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst      = 1'b1;
    start    = 1'b1;
    init_val = 8'h77;
    reg_mask = 8'h0F;
    x_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkCleared("reset");
    @(negedge clk);
    checkOutput("startDuringResetIgnored", {7'b0, x_valid}, 8'h00);

    // All-zero state is a fixed point: halts on the first accept
    x_ready = 1'b1;
    applyStimulus(8'h00, 8'h00);
    checkOutput("fixed_xValid", {7'b0, x_valid}, 8'h01);
    @(negedge clk);
    checkOutput("fixed_done", {7'b0, done}, 8'h01);
    checkOutput("fixed_cause", {6'b0, cause}, 8'h01);
    checkOutput("fixed_stepCnt", step_cnt, 8'h00);
    checkOutput("fixed_x", x, 8'h00);
    @(negedge clk);
    checkOutput("fixedHold_done", {7'b0, done}, 8'h01);
    checkOutput("fixedHold_xValid", {7'b0, x_valid}, 8'h00);

    // 55 <-> AA oscillation, restarted straight from DONE
    applyStimulus(8'h55, 8'h00);
    checkOutput("osc_x0", x, 8'h55);
    checkOutput("osc_done0", {7'b0, done}, 8'h00);
    @(negedge clk);
    checkOutput("osc_x1", x, 8'hAA);
    waitDone(40);
`ifdef GENE_NET_PERIOD2_EN
    checkOutput("osc_cause", {6'b0, cause}, 8'h02);
    checkOutput("osc_stepCnt", step_cnt, 8'h01);
    checkOutput("osc_x", x, 8'hAA);
`else
    checkOutput("osc_cause", {6'b0, cause}, 8'h03);
    checkOutput("osc_stepCnt", step_cnt, 8'h10);
    checkOutput("osc_x", x, 8'h55);
`endif

    // Single bit rotates left until the step limit
    applyStimulus(8'h01, 8'h00);
    for (int k = 0; k <= 16; k++) begin
      checkOutput("rot_x", x, 8'h01 << (k % 8));
      checkOutput("rot_stepCnt", step_cnt, 8'(k));
      @(negedge clk);
    end
    checkOutput("limit_done", {7'b0, done}, 8'h01);
    checkOutput("limit_cause", {6'b0, cause}, 8'h03);
    checkOutput("limit_stepCnt", step_cnt, 8'h10);
    checkOutput("limit_x", x, 8'h01);

    // Reset mid-run beats a simultaneous start and accept
    applyStimulus(8'h01, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("midRun_stepCnt", step_cnt, 8'h05);
    checkOutput("midRun_x", x, 8'h20);
    rst      = 1'b1;
    start    = 1'b1;
    init_val = 8'h3C;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkCleared("midRunReset");
    @(negedge clk);
    checkOutput("midRunStartIgnored_xValid", {7'b0, x_valid}, 8'h00);
    checkOutput("midRunStartIgnored_x", x, 8'h00);

    // Full mask with x_ready toggling: advances only on accept cycles
    x_ready = 1'b0;
    applyStimulus(8'h01, 8'hFF);
    checkOutput("tgl_x0", x, 8'h01);
    checkOutput("tgl_xValid", {7'b0, x_valid}, 8'h01);
    for (int k = 0; k < 6; k++) begin
      x_ready = (k % 2 == 0);
      @(negedge clk);
      checkOutput("tgl_x", x, tglExp[k]);
    end
    x_ready  = 1'b0;
    start    = 1'b1;
    init_val = 8'hAA;
    reg_mask = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checkOutput("startInRunIgnored_x", x, 8'h0F);
    checkOutput("startInRunIgnored_stepCnt", step_cnt, 8'h03);
    checkOutput("startInRunIgnored_xValid", {7'b0, x_valid}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
